// File: rtl/dma_timing_fsm.sv
// ---------------------------------------------------------------------------
// dma_timing_fsm
//
// Bus-cycle timing and control state machine for an 8237-style DMA
// controller. It takes the winning channel from the priority resolver,
// requests the bus with HRQ/HLDA, and steps each transfer through S0-S4.
// It also drives the address enable, the strobes, DACK enable, the
// count-decrement pulse and the terminal-count indications.
//
// Parameters
//   NCH          number of DMA channels (channel index is clog2(NCH) bits)
//
// Ports
//   CLK          clock; all state changes on the rising edge
//   RESET_N      synchronous active-low reset
//   ctrl_dis     command register disable; blocks new service only
//   grant_valid  the priority resolver has a winning channel
//   grant_ch     index of the winning channel
//   xfer_type    mode[3:2]: 00 verify, 01 write, 10 read, 11 verify
//   xfer_mode    mode[7:6]: 00 demand, 01 single, 10 block, 11 cascade
//   dreq_vec     per-channel valid DREQ flags (polarity already resolved)
//   HLDA         hold acknowledge from the CPU
//   READY        slow-device ready, sampled in S3
//   tc_in        the active channel's count is zero (last transfer)
//   EOP_N_IN     external end of process, active low
//   HRQ          hold request
//   AEN          address enable
//   ADSTB        upper-address strobe
//   MEMR_N, MEMW_N, IOR_N, IOW_N  active-low bus strobes
//   EOP_N_OUT    internal terminal count, active low
//   validDACK    DACK enable for the latched channel
//   dack_ch      latched channel index
//   cnt_dec      one-cycle pulse: step the address, decrement the count
//   tc_set       one-cycle pulse: set the channel's TC status bit
//   state        encoded state for debug
// ---------------------------------------------------------------------------
module dma_timing_fsm #(
    parameter int NCH = 4,
    parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           CLK,
    input  logic           RESET_N,
    input  logic           ctrl_dis,
    input  logic           grant_valid,
    input  logic [CW-1:0]  grant_ch,
    input  logic [1:0]     xfer_type,
    input  logic [1:0]     xfer_mode,
    input  logic [NCH-1:0] dreq_vec,
    input  logic           HLDA,
    input  logic           READY,
    input  logic           tc_in,
    input  logic           EOP_N_IN,
    output logic           HRQ,
    output logic           AEN,
    output logic           ADSTB,
    output logic           MEMR_N,
    output logic           MEMW_N,
    output logic           IOR_N,
    output logic           IOW_N,
    output logic           EOP_N_OUT,
    output logic           validDACK,
    output logic [CW-1:0]  dack_ch,
    output logic           cnt_dec,
    output logic           tc_set,
    output logic [2:0]     state
);

    typedef enum logic [2:0] {
        ST_SI = 3'd0,
        ST_S0 = 3'd1,
        ST_S1 = 3'd2,
        ST_S2 = 3'd3,
        ST_S3 = 3'd4,
        ST_S4 = 3'd5,
        ST_SC = 3'd6
    } state_t;

    localparam logic [1:0] TYPE_WRITE   = 2'b01;
    localparam logic [1:0] TYPE_READ    = 2'b10;

    localparam logic [1:0] MODE_DEMAND  = 2'b00;
    localparam logic [1:0] MODE_SINGLE  = 2'b01;
    localparam logic [1:0] MODE_BLOCK   = 2'b10;
    localparam logic [1:0] MODE_CASCADE = 2'b11;

    state_t         state_q, state_d;
    logic [CW-1:0]  ch_q, ch_d;
    logic [1:0]     type_q, type_d;
    logic [1:0]     mode_q, mode_d;
    logic           eop_q, eop_d;
    logic           tc_q, tc_d;

    logic           chan_dreq;
    logic           end_xfer;
    logic           is_read;
    logic           is_write;

    // DREQ of the channel that is currently being serviced.
    assign chan_dreq = dreq_vec[ch_q];

    // Termination seen at the S4 edge: terminal count captured on S4 entry,
    // a sticky EOP from earlier in the transfer, or EOP arriving right now.
    assign end_xfer  = tc_q | eop_q | ~EOP_N_IN;

    // Types 00 and 11 both behave as verify, so neither flag is set.
    assign is_read   = (type_q == TYPE_READ);
    assign is_write  = (type_q == TYPE_WRITE);

    // State and latched per-service context. Reset wins over everything,
    // which also aborts a transfer in flight before its S4 can occur.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= ST_SI;
            ch_q    <= '0;
            type_q  <= '0;
            mode_q  <= '0;
            eop_q   <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            type_q  <= type_d;
            mode_q  <= mode_d;
            eop_q   <= eop_d;
            tc_q    <= tc_d;
        end
    end

    // Next-state logic and context updates.
    // The channel, type and mode are captured only on the SI->S0 edge so the
    // resolver is free to move on while this service runs. tc_in is captured
    // on the S3->S4 edge so the S4 outputs depend only on registered values.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        type_d  = type_q;
        mode_d  = mode_q;
        eop_d   = eop_q;
        tc_d    = tc_q;

        case (state_q)
            ST_SI: begin
                eop_d = 1'b0;
                tc_d  = 1'b0;
                // HLDA must be seen low first so a hold is never reused
                // back-to-back from a previous service.
                if (grant_valid && !ctrl_dis && !HLDA) begin
                    state_d = ST_S0;
                    ch_d    = grant_ch;
                    type_d  = xfer_type;
                    mode_d  = xfer_mode;
                end
            end

            ST_S0: begin
                if (HLDA) begin
                    if (mode_q == MODE_CASCADE) begin
                        state_d = ST_SC;
                    end else if (!chan_dreq) begin
                        state_d = ST_SI;
                    end else begin
                        state_d = ST_S1;
                    end
                end
            end

            ST_S1: begin
                eop_d   = eop_q | ~EOP_N_IN;
                state_d = ST_S2;
            end

            ST_S2: begin
                eop_d   = eop_q | ~EOP_N_IN;
                state_d = ST_S3;
            end

            ST_S3: begin
                eop_d = eop_q | ~EOP_N_IN;
                if (READY) begin
                    state_d = ST_S4;
                    tc_d    = tc_in;
                end
            end

            ST_S4: begin
                eop_d = eop_q | ~EOP_N_IN;
                tc_d  = 1'b0;
                if (end_xfer) begin
                    state_d = ST_SI;
                end else begin
                    case (mode_q)
                        MODE_BLOCK:  state_d = ST_S1;
                        MODE_DEMAND: state_d = chan_dreq ? ST_S1 : ST_SI;
                        default:     state_d = ST_SI;
                    endcase
                end
            end

            ST_SC: begin
                // Cascade hands the bus to a downstream master; it is held
                // until that master drops its request or the CPU takes the
                // bus back.
                if (!chan_dreq || !HLDA) begin
                    state_d = ST_SI;
                end
            end

            default: begin
                state_d = ST_SI;
            end
        endcase

        // Entering SI always clears the sticky EOP so the next service
        // starts clean.
        if (state_d == ST_SI) begin
            eop_d = 1'b0;
        end
    end

    // Moore output decode from the registered state and latched context.
    // The read-side strobe opens in S2 and is held through S3; the
    // write-side strobe is only added in S3. Verify keeps every strobe high.
    always_comb begin
        HRQ       = 1'b0;
        AEN       = 1'b0;
        ADSTB     = 1'b0;
        MEMR_N    = 1'b1;
        MEMW_N    = 1'b1;
        IOR_N     = 1'b1;
        IOW_N     = 1'b1;
        EOP_N_OUT = 1'b1;
        validDACK = 1'b0;
        cnt_dec   = 1'b0;
        tc_set    = 1'b0;

        case (state_q)
            ST_S0: begin
                HRQ = 1'b1;
            end

            ST_S1: begin
                HRQ       = 1'b1;
                AEN       = 1'b1;
                ADSTB     = 1'b1;
                validDACK = 1'b1;
            end

            ST_S2: begin
                HRQ       = 1'b1;
                AEN       = 1'b1;
                validDACK = 1'b1;
                IOR_N     = ~is_write;
                MEMR_N    = ~is_read;
            end

            ST_S3: begin
                HRQ       = 1'b1;
                AEN       = 1'b1;
                validDACK = 1'b1;
                IOR_N     = ~is_write;
                MEMW_N    = ~is_write;
                MEMR_N    = ~is_read;
                IOW_N     = ~is_read;
            end

            ST_S4: begin
                HRQ       = 1'b1;
                AEN       = 1'b1;
                validDACK = 1'b1;
                cnt_dec   = 1'b1;
                tc_set    = tc_q;
                EOP_N_OUT = ~tc_q;
            end

            ST_SC: begin
                HRQ       = 1'b1;
                validDACK = 1'b1;
            end

            default: begin
            end
        endcase
    end

    assign dack_ch = ch_q;
    assign state   = state_q;

endmodule

// File: tb/tb_dma_timing_fsm.sv
// ---------------------------------------------------------------------------
// tb_dma_timing_fsm
//
// Directed bench for dma_timing_fsm. Each scenario drives inputs right
// after a rising edge and checks the registered state and decoded outputs
// one time unit after the next rising edge. Expected values are written
// out by hand from the state sequence each scenario should follow.
// ---------------------------------------------------------------------------
module tb_dma_timing_fsm;

    localparam logic [2:0] SI = 3'd0;
    localparam logic [2:0] S0 = 3'd1;
    localparam logic [2:0] S1 = 3'd2;
    localparam logic [2:0] S2 = 3'd3;
    localparam logic [2:0] S3 = 3'd4;
    localparam logic [2:0] S4 = 3'd5;
    localparam logic [2:0] SC = 3'd6;

    // Strobe nibble ordering: {MEMR_N, MEMW_N, IOR_N, IOW_N}
    localparam logic [3:0] STB_IDLE     = 4'b1111;
    localparam logic [3:0] STB_READ_S2  = 4'b0111;
    localparam logic [3:0] STB_READ_S3  = 4'b0110;
    localparam logic [3:0] STB_WRITE_S2 = 4'b1101;
    localparam logic [3:0] STB_WRITE_S3 = 4'b1001;

    logic       CLK;
    logic       RESET_N;
    logic       ctrl_dis;
    logic       grant_valid;
    logic [1:0] grant_ch;
    logic [1:0] xfer_type;
    logic [1:0] xfer_mode;
    logic [3:0] dreq_vec;
    logic       HLDA;
    logic       READY;
    logic       tc_in;
    logic       EOP_N_IN;
    logic       HRQ;
    logic       AEN;
    logic       ADSTB;
    logic       MEMR_N;
    logic       MEMW_N;
    logic       IOR_N;
    logic       IOW_N;
    logic       EOP_N_OUT;
    logic       validDACK;
    logic [1:0] dack_ch;
    logic       cnt_dec;
    logic       tc_set;
    logic [2:0] state;

    int checkCount = 0;
    int errorCount = 0;
    int decCount   = 0;
    int decBase    = 0;

    dma_timing_fsm #(.NCH(4)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .ctrl_dis   (ctrl_dis),
        .grant_valid(grant_valid),
        .grant_ch   (grant_ch),
        .xfer_type  (xfer_type),
        .xfer_mode  (xfer_mode),
        .dreq_vec   (dreq_vec),
        .HLDA       (HLDA),
        .READY      (READY),
        .tc_in      (tc_in),
        .EOP_N_IN   (EOP_N_IN),
        .HRQ        (HRQ),
        .AEN        (AEN),
        .ADSTB      (ADSTB),
        .MEMR_N     (MEMR_N),
        .MEMW_N     (MEMW_N),
        .IOR_N      (IOR_N),
        .IOW_N      (IOW_N),
        .EOP_N_OUT  (EOP_N_OUT),
        .validDACK  (validDACK),
        .dack_ch    (dack_ch),
        .cnt_dec    (cnt_dec),
        .tc_set     (tc_set),
        .state      (state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one clock and sample just after the edge; counts cnt_dec
    // pulses so pulse totals per scenario can be checked.
    task automatic step();
        @(posedge CLK);
        #1;
        if (cnt_dec) decCount++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic gv, input logic [1:0] ch,
                                 input logic [1:0] typ, input logic [1:0] mode,
                                 input logic [3:0] dreq, input logic hlda);
        grant_valid = gv;
        grant_ch    = ch;
        xfer_type   = typ;
        xfer_mode   = mode;
        dreq_vec    = dreq;
        HLDA        = hlda;
    endtask

    function automatic logic [3:0] strobes();
        return {MEMR_N, MEMW_N, IOR_N, IOW_N};
    endfunction

    initial begin
        RESET_N  = 1'b0;
        ctrl_dis = 1'b0;
        READY    = 1'b1;
        tc_in    = 1'b0;
        EOP_N_IN = 1'b1;
        applyStimulus(1'b0, 2'd0, 2'b00, 2'b00, 4'b0000, 1'b0);

        // ---------------- reset ----------------
        step();
        step();
        checkOutput("rst_state", state, SI);
        checkOutput("rst_hrq", HRQ, 1'b0);
        checkOutput("rst_strobes", strobes(), STB_IDLE);
        checkOutput("rst_cnt_dec", cnt_dec, 1'b0);
        checkOutput("rst_ctl", {AEN, ADSTB, validDACK, tc_set, EOP_N_OUT}, 5'b00001);
        checkOutput("rst_dack_ch", dack_ch, 2'd0);
        RESET_N = 1'b1;

        // ---------------- single read, channel 2 ----------------
        decBase = decCount;
        applyStimulus(1'b1, 2'd2, 2'b10, 2'b01, 4'b0100, 1'b0);
        step();
        checkOutput("sr_s0_state", state, S0);
        checkOutput("sr_s0_hrq", HRQ, 1'b1);
        applyStimulus(1'b0, 2'd0, 2'b00, 2'b00, 4'b0100, 1'b1);
        step();
        checkOutput("sr_s1_state", state, S1);
        checkOutput("sr_s1_ctl", {AEN, ADSTB, validDACK}, 3'b111);
        checkOutput("sr_dack_ch", dack_ch, 2'd2);
        checkOutput("sr_s1_strobes", strobes(), STB_IDLE);
        step();
        checkOutput("sr_s2_state", state, S2);
        checkOutput("sr_s2_strobes", strobes(), STB_READ_S2);
        checkOutput("sr_s2_adstb", ADSTB, 1'b0);
        step();
        checkOutput("sr_s3_state", state, S3);
        checkOutput("sr_s3_strobes", strobes(), STB_READ_S3);
        step();
        checkOutput("sr_s4_state", state, S4);
        checkOutput("sr_s4_strobes", strobes(), STB_IDLE);
        checkOutput("sr_s4_dec_tc", {cnt_dec, tc_set, EOP_N_OUT}, 3'b101);
        // HLDA still high and a fresh grant: no back-to-back service.
        grant_valid = 1'b1;
        step();
        checkOutput("sr_end_state", state, SI);
        checkOutput("sr_end_hrq", HRQ, 1'b0);
        step();
        checkOutput("sr_no_b2b_state", state, SI);
        checkOutput("sr_dec_count", decCount - decBase, 1);
        grant_valid = 1'b0;
        HLDA        = 1'b0;
        step();

        // ---------------- block write, tc on 3rd transfer ----------------
        decBase = decCount;
        applyStimulus(1'b1, 2'd1, 2'b01, 2'b10, 4'b0010, 1'b0);
        step();
        checkOutput("bw_s0_state", state, S0);
        applyStimulus(1'b0, 2'd0, 2'b00, 2'b00, 4'b0010, 1'b1);
        step();
        for (int k = 1; k <= 3; k++) begin
            checkOutput($sformatf("bw%0d_s1_state", k), state, S1);
            step();
            checkOutput($sformatf("bw%0d_s2_strobes", k), strobes(), STB_WRITE_S2);
            step();
            checkOutput($sformatf("bw%0d_s3_strobes", k), strobes(), STB_WRITE_S3);
            tc_in = (k == 3);
            step();
            checkOutput($sformatf("bw%0d_s4_state", k), state, S4);
            checkOutput($sformatf("bw%0d_s4_dec_tc_eop", k), {cnt_dec, tc_set, EOP_N_OUT},
                        (k == 3) ? 3'b110 : 3'b101);
            step();
        end
        tc_in = 1'b0;
        checkOutput("bw_end_state", state, SI);
        checkOutput("bw_dec_count", decCount - decBase, 3);
        HLDA = 1'b0;
        step();

        // ---------------- READY stretch, single write on ch3 ----------------
        decBase = decCount;
        applyStimulus(1'b1, 2'd3, 2'b01, 2'b01, 4'b1000, 1'b0);
        step();
        applyStimulus(1'b0, 2'd0, 2'b00, 2'b00, 4'b1000, 1'b1);
        step();
        step();
        checkOutput("rdy_s2_state", state, S2);
        READY = 1'b0;
        step();
        checkOutput("rdy_s3_first", state, S3);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("rdy_s3_hold%0d_state", i), state, S3);
            checkOutput($sformatf("rdy_s3_hold%0d_strobes", i), strobes(), STB_WRITE_S3);
            checkOutput($sformatf("rdy_s3_hold%0d_dec", i), cnt_dec, 1'b0);
        end
        READY = 1'b1;
        step();
        checkOutput("rdy_s4_state", state, S4);
        step();
        checkOutput("rdy_end_state", state, SI);
        checkOutput("rdy_dec_count", decCount - decBase, 1);
        HLDA = 1'b0;
        step();

        // ---------------- demand read, dreq drops in 2nd transfer ----------------
        decBase = decCount;
        applyStimulus(1'b1, 2'd1, 2'b10, 2'b00, 4'b0010, 1'b0);
        step();
        applyStimulus(1'b0, 2'd0, 2'b00, 2'b00, 4'b0010, 1'b1);
        step();
        step();
        step();
        step();
        checkOutput("dm1_s4_state", state, S4);
        step();
        checkOutput("dm2_s1_state", state, S1);
        step();
        dreq_vec = 4'b0000;
        step();
        step();
        checkOutput("dm2_s4_state", state, S4);
        step();
        checkOutput("dm_end_state", state, SI);
        checkOutput("dm_dec_count", decCount - decBase, 2);
        HLDA = 1'b0;
        step();

        // ---------------- block write, EOP in S2 ----------------
        decBase = decCount;
        applyStimulus(1'b1, 2'd0, 2'b01, 2'b10, 4'b0001, 1'b0);
        step();
        applyStimulus(1'b0, 2'd0, 2'b00, 2'b00, 4'b0001, 1'b1);
        step();
        step();
        checkOutput("eop_s2_state", state, S2);
        EOP_N_IN = 1'b0;
        step();
        EOP_N_IN = 1'b1;
        step();
        checkOutput("eop_s4_dec_tc_eop", {cnt_dec, tc_set, EOP_N_OUT}, 3'b101);
        step();
        checkOutput("eop_end_state", state, SI);
        checkOutput("eop_dec_count", decCount - decBase, 1);
        HLDA = 1'b0;
        step();

        // ---------------- cascade ----------------
        decBase = decCount;
        applyStimulus(1'b1, 2'd3, 2'b00, 2'b11, 4'b1000, 1'b0);
        step();
        applyStimulus(1'b0, 2'd0, 2'b00, 2'b00, 4'b1000, 1'b1);
        step();
        checkOutput("sc_state", state, SC);
        checkOutput("sc_ctl", {HRQ, validDACK, AEN, ADSTB}, 4'b1100);
        checkOutput("sc_strobes", strobes(), STB_IDLE);
        step();
        checkOutput("sc_hold_state", state, SC);
        dreq_vec = 4'b0000;
        step();
        checkOutput("sc_exit_state", state, SI);
        checkOutput("sc_dec_count", decCount - decBase, 0);
        HLDA = 1'b0;
        step();

        // ---------------- ctrl_dis blocks new service ----------------
        ctrl_dis = 1'b1;
        applyStimulus(1'b1, 2'd1, 2'b10, 2'b01, 4'b0010, 1'b0);
        step();
        step();
        checkOutput("dis_state", state, SI);
        checkOutput("dis_hrq", HRQ, 1'b0);
        ctrl_dis = 1'b0;
        step();
        checkOutput("dis_release_state", state, S0);

        // ---------------- reset in S3 aborts without cnt_dec ----------------
        decBase = decCount;
        grant_valid = 1'b0;
        HLDA        = 1'b1;
        step();
        step();
        step();
        checkOutput("abort_pre_state", state, S3);
        RESET_N = 1'b0;
        step();
        checkOutput("abort_state", state, SI);
        checkOutput("abort_cnt_dec", cnt_dec, 1'b0);
        checkOutput("abort_hrq", HRQ, 1'b0);
        RESET_N = 1'b1;
        HLDA    = 1'b0;
        step();
        checkOutput("abort_dec_count", decCount - decBase, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
